// File: rtl/serdes_align_ctrl_if.sv
// Data/status bundle between the ISERDES receive path and the word-alignment controller.
// The controller uses the slave modport; the stimulus/consumer side uses the master modport.
interface serdes_align_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             start_i;
  logic             stb_i;
  logic [WIDTH-1:0] dat_i;
  logic             bitslip_o;
  logic             locked_o;
  logic             fail_o;
  logic [7:0]       slip_cnt_o;
  logic [15:0]      err_cnt_o;

  modport master (
    output start_i, stb_i, dat_i,
    input  bitslip_o, locked_o, fail_o, slip_cnt_o, err_cnt_o
  );

  modport slave (
    input  start_i, stb_i, dat_i,
    output bitslip_o, locked_o, fail_o, slip_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/serdes_align_ctrl.sv
// ISERDES word-alignment controller: pulses BITSLIP until TRAIN_PATTERN is seen, then counts errors.
// Optional feature macro SERDES_ALIGN_RELOCK_EN: a run of RELOCK_THRESH bad words while locked re-aligns.
module serdes_align_ctrl #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'hA5,
  parameter int               BITSLIP_WAIT  = 3,
  parameter int               MATCH_COUNT   = 4,
  parameter int               MAX_SLIPS     = 8,
  parameter int               RELOCK_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  serdes_align_ctrl_if.slave bus
);

  localparam int SW = $clog2(BITSLIP_WAIT + 1);
  localparam int MW = $clog2(MATCH_COUNT + 1);

  if ((BITSLIP_WAIT < 1) || (MATCH_COUNT < 1) || (RELOCK_THRESH < 1)) begin : g_bad_cfg
    $error("serdes_align_ctrl: BITSLIP_WAIT, MATCH_COUNT and RELOCK_THRESH must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_SLIP,
    S_LOCK,
    S_FAIL
  } state_t;

  state_t          state_q;
  logic            bitslip_q;
  logic            locked_q;
  logic            fail_q;
  logic [7:0]      slip_cnt_q;
  logic [15:0]     err_cnt_q;
  logic [SW-1:0]   stb_cnt_q;
  logic [MW-1:0]   match_cnt_q;
`ifdef SERDES_ALIGN_RELOCK_EN
  localparam int RW = $clog2(RELOCK_THRESH + 1);
  logic [RW-1:0]   run_cnt_q;
`endif

  logic hit;
  assign hit = (bus.dat_i == TRAIN_PATTERN);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bitslip_q   <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      slip_cnt_q  <= '0;
      err_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      match_cnt_q <= '0;
`ifdef SERDES_ALIGN_RELOCK_EN
      run_cnt_q   <= '0;
`endif
    end else if (bus.start_i) begin
      // START overrides every state, including a BITSLIP that would otherwise issue now
      state_q     <= S_WAIT;
      bitslip_q   <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      slip_cnt_q  <= '0;
      err_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      match_cnt_q <= '0;
`ifdef SERDES_ALIGN_RELOCK_EN
      run_cnt_q   <= '0;
`endif
    end else begin
      bitslip_q <= 1'b0;
      case (state_q)
        S_IDLE: ;
        S_WAIT: begin
          if (bus.stb_i) begin
            if (stb_cnt_q == SW'(BITSLIP_WAIT - 1)) begin
              stb_cnt_q <= '0;
              state_q   <= S_CHECK;
            end else begin
              stb_cnt_q <= stb_cnt_q + SW'(1);
            end
          end
        end
        S_CHECK: begin
          if (bus.stb_i) begin
            if (hit) begin
              if (match_cnt_q == MW'(MATCH_COUNT - 1)) begin
                match_cnt_q <= '0;
                locked_q    <= 1'b1;
                state_q     <= S_LOCK;
              end else begin
                match_cnt_q <= match_cnt_q + MW'(1);
              end
            end else begin
              match_cnt_q <= '0;
              if (slip_cnt_q < 8'(MAX_SLIPS)) begin
                bitslip_q  <= 1'b1;
                slip_cnt_q <= slip_cnt_q + 8'd1;
                state_q    <= S_SLIP;
              end else begin
                fail_q  <= 1'b1;
                state_q <= S_FAIL;
              end
            end
          end
        end
        S_SLIP: begin
          // Strobes during the slip cycle are dropped; the settle count restarts in WAIT
          stb_cnt_q <= '0;
          state_q   <= S_WAIT;
        end
        S_LOCK: begin
          if (bus.stb_i) begin
            if (!hit) begin
              err_cnt_q <= sat_inc16(err_cnt_q);
`ifdef SERDES_ALIGN_RELOCK_EN
              if (run_cnt_q == RW'(RELOCK_THRESH - 1)) begin
                run_cnt_q  <= '0;
                locked_q   <= 1'b0;
                bitslip_q  <= 1'b1;
                slip_cnt_q <= 8'd1;
                state_q    <= S_SLIP;
              end else begin
                run_cnt_q <= run_cnt_q + RW'(1);
              end
            end else begin
              run_cnt_q <= '0;
`endif
            end
          end
        end
        S_FAIL: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.bitslip_o  = bitslip_q;
  assign bus.locked_o   = locked_q;
  assign bus.fail_o     = fail_q;
  assign bus.slip_cnt_o = slip_cnt_q;
  assign bus.err_cnt_o  = err_cnt_q;

endmodule
